rc_int_fifo_arb: RTL and testbench
==================================

RC_INT_FIFO_ARB -- requirements
Module: rc_int_fifo_arb

Interface
REQ-001 SHALL have parameter NumRcInt, default 8, meaning the number of RC interrupt FIFO channels (2..16).
REQ-002 SHALL have parameter MaxBurst, default 4, meaning the maximum pops per grant (1..7).
REQ-003 SHALL have parameter Watermark, default 6, meaning the high-water level used only when RC_INT_ARB_WATERMARK_EN is defined (1..7).
REQ-004 SHALL have port clk, input, 1, the single clock; all state is rising-edge clocked.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port amf_rc_int_fifo_level, input, [NumRcInt-1:0][2:0], per-channel FIFO occupancy (0..7).
REQ-007 SHALL have port pop_ready, input, 1, downstream accepts a pop this cycle.
REQ-008 SHALL have port pop_valid, output, 1, a pop from channel pop_sel is requested.
REQ-009 SHALL have port pop_sel, output, $clog2(NumRcInt), index of the granted channel.
REQ-010 SHALL have port grant, output, [NumRcInt-1:0], one-hot granted channel, all-zero when none.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL treat channel i as eligible when amf_rc_int_fifo_level[i] != 0.
REQ-013 SHALL implement FSM states IDLE, BURST, GAP.
REQ-014 SHALL, in IDLE with at least one eligible channel, select a winner by round-robin search starting at rr_ptr and enter BURST on the next edge.
REQ-015 SHALL, on entry to BURST, load remaining = min(level[winner], MaxBurst) and set grant/pop_sel to the winner.
REQ-016 SHALL assert pop_valid exactly when in BURST; first pop_valid occurs one cycle after the IDLE cycle in which eligibility is seen.
REQ-017 SHALL count a pop only on a cycle with pop_valid && pop_ready, decrementing remaining by 1.
REQ-018 SHALL hold pop_sel and grant stable while pop_valid && !pop_ready (no withdrawal, no channel change).
REQ-019 SHALL leave BURST for GAP on the edge where the pop that makes remaining zero is accepted, yielding at most MaxBurst pops per grant.
REQ-020 SHALL never pop more than the level snapshotted at grant, regardless of level changes during BURST.
REQ-021 SHALL set rr_ptr = (winner + 1) mod NumRcInt on BURST exit; wrap from NumRcInt-1 to 0.
REQ-022 SHALL spend exactly one cycle in GAP (grant=0, pop_valid=0) to let producer levels settle, then return to IDLE.
REQ-023 SHALL remain in IDLE with grant=0 when no channel is eligible.
REQ-024 SHALL ignore level increases on non-granted channels until the next arbitration in IDLE.

Reset
REQ-025 SHALL, on rst_n low, immediately force state=IDLE, rr_ptr=0, remaining=0, pop_valid=0, pop_sel=0, grant=0, busy=0, including mid-burst.
REQ-026 SHALL begin arbitration on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL support macro RC_INT_ARB_WATERMARK_EN: when defined, channels with level >= Watermark win over other eligible channels, with round-robin from rr_ptr within each class; when undefined, plain round-robin over all eligible channels and parameter Watermark is unused.

Verification
REQ-028 SHALL cover: reset, level[3]=5, pop_ready=1 -> pop_sel=3, four pops on consecutive cycles, one GAP cycle, rr_ptr=4.
REQ-029 SHALL cover: level[0]=2, level[7]=3, rr_ptr=7 -> grant ch7 (3 pops), then ch0 (2 pops), demonstrating wrap.
REQ-030 SHALL cover: BURST on ch2, pop_ready low for 3 cycles -> pop_valid held high, pop_sel=2 unchanged, no pop counted.
REQ-031 SHALL cover: rst_n pulsed low after 2 of 4 pops -> all outputs 0 same cycle, next grant searches from 0.
REQ-032 SHALL cover (RC_INT_ARB_WATERMARK_EN defined): level[1]=2, level[5]=6, rr_ptr=0 -> ch5 granted first; same stimulus with macro undefined -> ch1 first.
REQ-033 SHALL cover: level[4] rises 1->7 during its burst -> exactly 1 pop, then GAP.

Source files
------------

// File: rtl/rc_int_fifo_arb.sv
// Round-robin arbiter that grants bounded pop bursts to RC interrupt FIFO channels.
// Optional RC_INT_ARB_WATERMARK_EN: channels at/above Watermark win over other eligible channels.
module rc_int_fifo_arb #(
    parameter int NumRcInt  = 8,
    parameter int MaxBurst  = 4,
    parameter int Watermark = 6,
    localparam int SelW     = $clog2(NumRcInt)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NumRcInt-1:0][2:0] amf_rc_int_fifo_level,
    input  logic                     pop_ready,
    output logic                     pop_valid,
    output logic [SelW-1:0]          pop_sel,
    output logic [NumRcInt-1:0]      grant,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [2:0] BurstLvl = 3'(MaxBurst);
    localparam logic [2:0] WmLvl    = 3'(Watermark);

    state_e          state_q, state_d;
    logic [SelW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic [2:0]      rem_q, rem_d;

    logic            any_found;
    logic [SelW-1:0] any_idx;
    logic            hi_found;
    logic [SelW-1:0] hi_idx;
    logic [SelW-1:0] win_idx;
    logic [2:0]      win_lvl;
    logic [2:0]      rem_load;

    function automatic logic [SelW-1:0] wrap_idx(input logic [SelW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NumRcInt) s = s - NumRcInt;
        return SelW'(s);
    endfunction

    // Two parallel searches from rr_ptr: any eligible channel, and high-water channels only.
    always_comb begin
        any_found = 1'b0;
        any_idx   = '0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        for (int k = 0; k < NumRcInt; k++) begin
            if (!any_found && amf_rc_int_fifo_level[wrap_idx(rr_ptr_q, k)] != 3'd0) begin
                any_found = 1'b1;
                any_idx   = wrap_idx(rr_ptr_q, k);
            end
            if (!hi_found && amf_rc_int_fifo_level[wrap_idx(rr_ptr_q, k)] >= WmLvl) begin
                hi_found = 1'b1;
                hi_idx   = wrap_idx(rr_ptr_q, k);
            end
        end
    end

`ifdef RC_INT_ARB_WATERMARK_EN
    assign win_idx = (hi_found && WmLvl != 3'd0) ? hi_idx : any_idx;
`else
    logic unused_hi;
    assign unused_hi = hi_found ^ (^hi_idx);
    assign win_idx   = any_idx;
`endif

    assign win_lvl  = amf_rc_int_fifo_level[win_idx];
    assign rem_load = (win_lvl > BurstLvl) ? BurstLvl : win_lvl;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        rem_d    = rem_q;
        unique case (state_q)
            IDLE: begin
                if (any_found) begin
                    state_d = BURST;
                    sel_d   = win_idx;
                    rem_d   = rem_load;
                end
            end
            BURST: begin
                // Burst length is fixed at grant time; later level changes are ignored.
                if (pop_ready) begin
                    if (rem_q <= 3'd1) begin
                        state_d  = GAP;
                        rem_d    = 3'd0;
                        rr_ptr_d = wrap_idx(sel_q, 1);
                    end else begin
                        rem_d = rem_q - 3'd1;
                    end
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            rem_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            rem_q    <= rem_d;
        end
    end

    assign pop_valid = (state_q == BURST);
    assign pop_sel   = sel_q;
    assign grant     = pop_valid ? (NumRcInt'(1) << sel_q) : '0;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rc_int_fifo_arb.sv
// Directed bench for rc_int_fifo_arb: vector table for the round-robin flow plus corner sequences.
module tb_rc_int_fifo_arb;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0][2:0] level = '0;
    logic            pop_ready = 1'b0;
    logic            pop_valid;
    logic [2:0]      pop_sel;
    logic [7:0]      grant;
    logic            busy;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];
    logic [2:0] act_q[$];
    logic       mon_en = 1'b0;

    typedef struct {
        logic [7:0][2:0] lvl;
        logic            rdy;
        logic            v;
        logic [2:0]      sel;
        logic [7:0]      g;
        logic            b;
    } vec_t;

    vec_t tbl[22];

    rc_int_fifo_arb dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .amf_rc_int_fifo_level (level),
        .pop_ready             (pop_ready),
        .pop_valid             (pop_valid),
        .pop_sel               (pop_sel),
        .grant                 (grant),
        .busy                  (busy),
        .dbg_state             (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // accepted-pop monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (mon_en && pop_valid && pop_ready) act_q.push_back(pop_sel);
    end

    function automatic logic [7:0][2:0] lv(input int a, input int va, input int b, input int vb);
        logic [7:0][2:0] r;
        r = '0;
        if (a >= 0) r[a] = 3'(va);
        if (b >= 0) r[b] = 3'(vb);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic v, input logic [2:0] sel,
                           input logic [7:0] g, input logic b);
        check({tag, "_valid"}, 32'(pop_valid), 32'(v));
        check({tag, "_sel"},   32'(pop_sel),   32'(sel));
        check({tag, "_grant"}, 32'(grant),     32'(g));
        check({tag, "_busy"},  32'(busy),      32'(b));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        level     = '0;
        pop_ready = 1'b0;
        step();
        exp_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] exp32;

        // round-robin flow: ch3 burst of 4, rr from 4, wrap 7 -> 0, idle with nothing eligible
        tbl[0]  = '{lv(3,5,-1,0), 1'b1, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[1]  = '{lv(3,5,-1,0), 1'b1, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[2]  = '{lv(3,5,-1,0), 1'b1, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[3]  = '{lv(3,5,-1,0), 1'b1, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[4]  = '{lv(-1,0,-1,0), 1'b1, 1'b0, 3'd3, 8'h00, 1'b1};
        tbl[5]  = '{lv(2,1,5,1),  1'b1, 1'b0, 3'd3, 8'h00, 1'b0};
        tbl[6]  = '{lv(2,1,5,1),  1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
        tbl[7]  = '{lv(-1,0,-1,0), 1'b1, 1'b0, 3'd5, 8'h00, 1'b1};
        tbl[8]  = '{lv(6,1,-1,0), 1'b1, 1'b0, 3'd5, 8'h00, 1'b0};
        tbl[9]  = '{lv(6,1,-1,0), 1'b1, 1'b1, 3'd6, 8'h40, 1'b1};
        tbl[10] = '{lv(0,2,7,3),  1'b1, 1'b0, 3'd6, 8'h00, 1'b1};
        tbl[11] = '{lv(0,2,7,3),  1'b1, 1'b0, 3'd6, 8'h00, 1'b0};
        tbl[12] = '{lv(0,2,7,3),  1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
        tbl[13] = '{lv(0,2,7,3),  1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
        tbl[14] = '{lv(0,2,7,3),  1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
        tbl[15] = '{lv(0,2,7,3),  1'b1, 1'b0, 3'd7, 8'h00, 1'b1};
        tbl[16] = '{lv(0,2,7,3),  1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
        tbl[17] = '{lv(0,2,7,3),  1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
        tbl[18] = '{lv(0,2,7,3),  1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
        tbl[19] = '{lv(-1,0,-1,0), 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
        tbl[20] = '{lv(-1,0,-1,0), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
        tbl[21] = '{lv(-1,0,-1,0), 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
        exp_q = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0};

        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 22; i++) begin
            level     = tbl[i].lvl;
            pop_ready = tbl[i].rdy;
            step();
            exp_out($sformatf("row%0d", i), tbl[i].v, tbl[i].sel, tbl[i].g, tbl[i].b);
        end
        mon_en = 1'b0;
        check("pop_count", 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("pop%0d_ch", i), 32'(act_q[i]), 32'(exp_q[i]));

        // stall: pop_ready low holds the request and counts nothing
        do_reset();
        level = lv(2,3,-1,0);
        pop_ready = 1'b0;
        step();
        exp_out("stall_grant", 1'b1, 3'd2, 8'h04, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_out($sformatf("stall_hold%0d", i), 1'b1, 3'd2, 8'h04, 1'b1);
        end
        pop_ready = 1'b1;
        step();
        exp_out("stall_pop1", 1'b1, 3'd2, 8'h04, 1'b1);
        step();
        exp_out("stall_pop2", 1'b1, 3'd2, 8'h04, 1'b1);
        level = '0;
        step();
        exp_out("stall_gap", 1'b0, 3'd2, 8'h00, 1'b1);

        // asynchronous reset mid-burst, then search restarts from channel 0
        do_reset();
        level = lv(1,4,-1,0);
        pop_ready = 1'b1;
        step();
        exp_out("mrst_grant", 1'b1, 3'd1, 8'h02, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        exp_out("mrst_async", 1'b0, 3'd0, 8'h00, 1'b0);
        level = lv(1,1,3,1);
        step();
        exp_out("mrst_held", 1'b0, 3'd0, 8'h00, 1'b0);
        rst_n = 1'b1;
        step();
        exp_out("mrst_regrant", 1'b1, 3'd1, 8'h02, 1'b1);

        // level rising during the burst does not extend it
        do_reset();
        level = lv(4,1,-1,0);
        pop_ready = 1'b1;
        step();
        exp_out("rise_grant", 1'b1, 3'd4, 8'h10, 1'b1);
        level = lv(4,7,-1,0);
        step();
        exp_out("rise_gap", 1'b0, 3'd4, 8'h00, 1'b1);
        level = '0;
        step();
        exp_out("rise_idle", 1'b0, 3'd4, 8'h00, 1'b0);

        // watermark priority versus plain round-robin
`ifdef RC_INT_ARB_WATERMARK_EN
        exp32 = 3'd5;
`else
        exp32 = 3'd1;
`endif
        do_reset();
        level = lv(1,2,5,6);
        pop_ready = 1'b1;
        step();
        exp_out("wm_first", 1'b1, exp32, 8'h01 << exp32, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
